// File: rtl/sa_skew_sequencer_if.sv
// Tile-controller to skew-sequencer bundle.
// Operand buffers and start request in; array drive and status out.
interface sa_skew_sequencer_if #(
    parameter int DATA_BITS = 32
);
    logic                 start;
    logic                 acc;
    logic [DATA_BITS-1:0] buf_a0;
    logic [DATA_BITS-1:0] buf_a1;
    logic [DATA_BITS-1:0] buf_a2;
    logic [DATA_BITS-1:0] buf_a3;
    logic [DATA_BITS-1:0] buf_b0;
    logic [DATA_BITS-1:0] buf_b1;
    logic [DATA_BITS-1:0] buf_b2;
    logic [DATA_BITS-1:0] buf_b3;
    logic                 busy;
    logic                 sa_clr;
    logic                 sa_en;
    logic [DATA_BITS-1:0] sa_a_in;
    logic [DATA_BITS-1:0] sa_b_in;
    logic                 done;

    modport master (
        output start, acc,
        output buf_a0, buf_a1, buf_a2, buf_a3,
        output buf_b0, buf_b1, buf_b2, buf_b3,
        input  busy, sa_clr, sa_en, sa_a_in, sa_b_in, done
    );

    modport slave (
        input  start, acc,
        input  buf_a0, buf_a1, buf_a2, buf_a3,
        input  buf_b0, buf_b1, buf_b2, buf_b3,
        output busy, sa_clr, sa_en, sa_a_in, sa_b_in, done
    );
endinterface

// File: rtl/sa_skew_sequencer.sv
// Sequences one 4x4x4 tile through the systolic array:
// capture, optional clear, skewed feed, drain, done pulse.
module sa_skew_sequencer #(
    parameter int ELEM_BITS    = 8,
    parameter int DATA_BITS    = 4 * ELEM_BITS,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    sa_skew_sequencer_if.slave bus
);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [2:0]           t_q;
    logic [2:0]           t_d;
    logic [DW-1:0]        d_q;
    logic [DW-1:0]        d_d;
    logic [DATA_BITS-1:0] a_q [4];
    logic [DATA_BITS-1:0] b_q [4];
    logic                 acc_q;
    logic [DATA_BITS-1:0] a_lane;
    logic [DATA_BITS-1:0] b_lane;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            d_q     <= d_d;
        end
    end

    // Operand capture; only an accepted start in IDLE loads the buffers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            acc_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            a_q[0] <= bus.buf_a0;
            a_q[1] <= bus.buf_a1;
            a_q[2] <= bus.buf_a2;
            a_q[3] <= bus.buf_a3;
            b_q[0] <= bus.buf_b0;
            b_q[1] <= bus.buf_b1;
            b_q[2] <= bus.buf_b2;
            b_q[3] <= bus.buf_b3;
            acc_q  <= bus.acc;
        end
    end

    // Next-state logic; each counted state leaves on its terminal count.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = FEED;
                t_d     = '0;
            end
            FEED: begin
                if (t_q == 3'd6) begin
                    state_d = DRAIN;
                    t_d     = '0;
                    d_d     = '0;
                end else begin
                    t_d = t_q + 3'd1;
                end
            end
            DRAIN: begin
                if (d_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d = DONE;
                    d_d     = '0;
                end else begin
                    d_d = d_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Diagonal skew: edge lane r at step t carries element t-r of word r.
    always_comb begin
        a_lane = '0;
        b_lane = '0;
        if (state_q == FEED) begin
            for (int r = 0; r < 4; r++) begin
                if (t_q >= 3'(r) && (t_q - 3'(r)) <= 3'd3) begin
                    a_lane[r*ELEM_BITS +: ELEM_BITS] =
                        a_q[r][int'(t_q - 3'(r)) * ELEM_BITS +: ELEM_BITS];
                    b_lane[r*ELEM_BITS +: ELEM_BITS] =
                        b_q[r][int'(t_q - 3'(r)) * ELEM_BITS +: ELEM_BITS];
                end
            end
        end
    end

    // Status and array controls decode from registered state only.
    always_comb begin
        bus.busy    = (state_q != IDLE);
        bus.sa_clr  = (state_q == CLEAR) && !acc_q;
        bus.sa_en   = (state_q == FEED) || (state_q == DRAIN);
        bus.done    = (state_q == DONE);
        bus.sa_a_in = a_lane;
        bus.sa_b_in = b_lane;
    end
endmodule

// File: tb/tb_sa_skew_sequencer.sv
// Directed bench for sa_skew_sequencer: skew tables, acc mode,
// ignored starts, reset abort and back-to-back timing.
module tb_sa_skew_sequencer;
    localparam int DB = 32;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;

    sa_skew_sequencer_if #(.DATA_BITS(DB)) bus ();

    sa_skew_sequencer #(
        .ELEM_BITS   (8),
        .DATA_BITS   (DB),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // A words 04030201.. skewed, t=0..6
    logic [31:0] tbl_a [7] = '{
        32'h00000001, 32'h00001102, 32'h00211203, 32'h31221304,
        32'h32231400, 32'h33240000, 32'h34000000
    };
    // B words 44434241.. skewed, t=0..6
    logic [31:0] tbl_b [7] = '{
        32'h00000041, 32'h00005142, 32'h00615243, 32'h71625344,
        32'h72635400, 32'h73640000, 32'h74000000
    };
    logic [31:0] cur_a [7];
    logic [31:0] cur_b [7];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_bufs(input logic [31:0] a0, a1, a2, a3,
                            input logic [31:0] b0, b1, b2, b3);
        bus.buf_a0 = a0; bus.buf_a1 = a1;
        bus.buf_a2 = a2; bus.buf_a3 = a3;
        bus.buf_b0 = b0; bus.buf_b1 = b1;
        bus.buf_b2 = b2; bus.buf_b3 = b3;
    endtask

    task automatic bufs_ab();
        set_bufs(32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231,
                 32'h44434241, 32'h54535251, 32'h64636261, 32'h74737271);
        cur_a = tbl_a;
        cur_b = tbl_b;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, 32'(bus.busy), 32'd0);
        check({tag, ".clr"},  32'(bus.sa_clr), 32'd0);
        check({tag, ".en"},   32'(bus.sa_en), 32'd0);
        check({tag, ".done"}, 32'(bus.done), 32'd0);
        check({tag, ".a"},    bus.sa_a_in, 32'd0);
        check({tag, ".b"},    bus.sa_b_in, 32'd0);
    endtask

    // rel: cycle number relative to the start-sampling cycle 0
    task automatic check_cycle(input int c, input int rel, input bit accv);
        string s;
        logic [31:0] ea;
        logic [31:0] eb;
        s = $sformatf("c%0d", c);
        ea = (rel >= 2 && rel <= 8) ? cur_a[rel-2] : 32'd0;
        eb = (rel >= 2 && rel <= 8) ? cur_b[rel-2] : 32'd0;
        check({s, ".busy"}, 32'(bus.busy), 32'(rel >= 1 && rel <= 9 + DC));
        check({s, ".clr"},  32'(bus.sa_clr), 32'(rel == 1 && !accv));
        check({s, ".en"},   32'(bus.sa_en), 32'(rel >= 2 && rel <= 8 + DC));
        check({s, ".done"}, 32'(bus.done), 32'(rel == 9 + DC));
        check({s, ".a"},    bus.sa_a_in, ea);
        check({s, ".b"},    bus.sa_b_in, eb);
    endtask

    task automatic run_op(input bit accv, input bit ign, input bit b2b);
        int last;
        int rel;
        last = b2b ? 28 : 15;
        @(negedge clk);
        bus.acc   = accv;
        bus.start = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            rel = (b2b && c >= 15) ? c - 14 : c;
            check_cycle(c, rel, accv);
            bus.start = 1'b0;
            if (ign && (c == 4 || c == 13)) begin
                bus.start = 1'b1;
                set_bufs('1, '1, '1, '1, '1, '1, '1, '1);
            end
            if (b2b && c == 14) begin
                bus.start = 1'b1;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.acc   = 1'b0;
        bufs_ab();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 1'b0, 1'b0);

        set_bufs(32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231,
                 32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231);
        cur_a = tbl_a;
        cur_b = tbl_a;
        run_op(1'b1, 1'b0, 1'b0);

        bufs_ab();
        run_op(1'b0, 1'b1, 1'b0);

        bufs_ab();
        @(negedge clk);
        bus.acc   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check("abort.t3", bus.sa_a_in, 32'h31221304);
        rst = 1'b1;
        #1;
        check_zero("abort");
        @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("post%0d.done", i), 32'(bus.done), 32'd0);
            check($sformatf("post%0d.busy", i), 32'(bus.busy), 32'd0);
        end
        run_op(1'b0, 1'b0, 1'b0);

        run_op(1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sa_skew_sequencer.md
# sa_skew_sequencer

Sequences one 4x4x4 tile operation on the output-stationary systolic array. It latches four A row words and four B column words on a start pulse, optionally clears the PE accumulators, and feeds the operands into the array edges with the diagonal skew the array needs. It then waits out the array drain and pulses `done`. It sits between the TPU tile controller, which fills the local A/B buffers and waits on `done`, and the systolic array.

## Interface
- `ELEM_BITS`, default 8: width of one operand element (int8).
- `DATA_BITS`, default 32: width of a packed word, 4 x `ELEM_BITS`; lane k is bits [8k+7:8k].
- `DRAIN_CYCLES`, default 4: cycles `sa_en` stays high after the last feed cycle; must be >= 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request for one tile operation; sampled only in IDLE.
- `acc` in 1: sampled with `start`; 1 = accumulate onto existing PE sums (no clear).
- `buf_a0`..`buf_a3` in `DATA_BITS` each: A row r, lane k = A[r][k].
- `buf_b0`..`buf_b3` in `DATA_BITS` each: B column c, lane k = B[k][c].
- `busy` out 1: operation in progress.
- `sa_clr` out 1: one-cycle accumulator clear to the array.
- `sa_en` out 1: array shift/MAC enable.
- `sa_a_in` out `DATA_BITS`: lane r drives left edge of array row r.
- `sa_b_in` out `DATA_BITS`: lane c drives top edge of array column c.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: `busy`=0. On `start`=1, capture all eight buffer words and `acc` into internal registers and go to CLEAR.
- CLEAR: one cycle. `sa_clr`=~acc_q, `sa_en`=0. Go to FEED with feed counter t=0.
- FEED: 7 cycles, t=0..6. `sa_en`=1. Lane r of `sa_a_in` = A_q[r][t-r] if 0 <= t-r <= 3, else 0. Lane c of `sa_b_in` = B_q[t-c][c] under the same rule. After t=6, go to DRAIN.
- DRAIN: `DRAIN_CYCLES` cycles. `sa_en`=1, `sa_a_in`=`sa_b_in`=0. Then go to DONE.
- DONE: one cycle. `done`=1, `sa_en`=0. Then go to IDLE.
- `busy`=1 in CLEAR, FEED, DRAIN and DONE.
- `start` outside IDLE, including the DONE cycle, is ignored and not queued.
- Buffer inputs are don't-care after the capture edge. Changing them mid-operation has no effect.
- All outputs decode from registered state, counters and captured operands. There is no combinational path from any input to any output.
- Counters: t is 3 bits. The drain counter is clog2(`DRAIN_CYCLES`+1) bits. Neither counter wraps, because each state exits on its terminal count.

## Timing
- Reset (`rst`=1, asynchronous): state=IDLE, counters=0, captured operands=0, acc_q=0. All outputs go to 0 immediately: `busy`, `sa_clr`, `sa_en`, `sa_a_in`, `sa_b_in`, `done`.
- Reset mid-operation: the operation aborts, no `done` is issued, and the block is in IDLE when `rst` falls.
- Cycle numbering: cycle 0 ends with the edge that samples `start`.
  - Cycle 1: CLEAR.
  - Cycles 2..8: FEED t=0..6.
  - Cycles 9..8+`DRAIN_CYCLES`: DRAIN.
  - Cycle 9+`DRAIN_CYCLES`: DONE. With the default this is cycle 13.
- Start-to-done latency is 9+`DRAIN_CYCLES` cycles, fixed and independent of `acc`.
- The earliest next accepted `start` is sampled in the first IDLE cycle after DONE. Back-to-back operations therefore have a period of 10+`DRAIN_CYCLES` cycles.
- Handshake with the array: `sa_clr` and `sa_en` are never both 1. The array must register `sa_a_in`/`sa_b_in` on the edge that ends each cycle with `sa_en`=1.

## Test plan
- **Skew pattern:** `buf_a0`=32'h04030201, `buf_a1`=32'h14131211, `buf_a2`=32'h24232221, `buf_a3`=32'h34333231, `acc`=0, start.
  - `sa_clr`=1 in cycle 1.
  - t=0: `sa_a_in`=32'h00000001.
  - t=3: `sa_a_in`=32'h31221304.
  - t=6: `sa_a_in`=32'h34000000.
  - `done`=1 exactly in cycle 13.
- **B mirror:** `buf_b0`..`buf_b3` set to the same values as the A words above.
  - `sa_b_in` follows the same lane pattern.
  - At t=4: `sa_b_in`=32'h32231400.
- **Accumulate mode:** `acc`=1 with otherwise identical stimulus.
  - `sa_clr` stays 0 throughout.
  - All other outputs match the `acc`=0 run cycle for cycle.
- **Ignored starts:** pulse `start` in FEED t=2 and again in the DONE cycle, with buffers changed to 32'hFFFFFFFF.
  - Output lanes never show FF.
  - Exactly one `done` pulse.
  - `busy` drops in cycle 14.
- **Reset abort:** assert `rst` asynchronously, mid-cycle, during FEED t=3.
  - All outputs are 0 before the next edge.
  - No `done` is issued.
  - A new start after `rst` falls yields `done` 13 cycles later.
- **Back-to-back:** second `start` in cycle 14.
  - Second `sa_clr` in cycle 15.
  - Second `done` in cycle 27.
